// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and helpers.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    // True for the multi-cycle ops; the hazard unit uses this to decide what to stall.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; produces the full {hi, lo} result for one op.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             div_by_zero
);

    logic signed [2*WIDTH-1:0] a_sext;
    logic signed [2*WIDTH-1:0] b_sext;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic                      a_neg;
    logic                      b_neg;
    logic [WIDTH-1:0]          a_mag;
    logic [WIDTH-1:0]          b_mag;
    logic [WIDTH-1:0]          q_mag;
    logic [WIDTH-1:0]          r_mag;
    logic [WIDTH-1:0]          quot;
    logic [WIDTH-1:0]          rem;

    // Signed division runs on magnitudes and re-applies signs, which also makes
    // most-negative / -1 fall out as most-negative with a zero remainder.
    always_comb begin
        a_sext      = {{WIDTH{a[WIDTH-1]}}, a};
        b_sext      = {{WIDTH{b[WIDTH-1]}}, b};
        prod_s      = a_sext * b_sext;
        prod_u      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        a_neg       = (op == MDU_DIV) && a[WIDTH-1];
        b_neg       = (op == MDU_DIV) && b[WIDTH-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == '0);
        q_mag       = (b == '0) ? '0 : a_mag / b_mag;
        r_mag       = (b == '0) ? '0 : a_mag % b_mag;
        quot        = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem         = a_neg ? -r_mag : r_mag;
        hi_next     = '0;
        lo_next     = '0;
        case (op)
            MDU_MULT:  {hi_next, lo_next} = prod_s;
            MDU_MULTU: {hi_next, lo_next} = prod_u;
            MDU_DIV, MDU_DIVU: begin
                hi_next = rem;
                lo_next = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mul_div_unit.sv
// Execute-stage multiply/divide unit: HI/LO registers with a fixed-latency busy window.
module e_mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       mdu_op,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] issue_lat;
    logic [WIDTH-1:0] pending_hi;
    logic [WIDTH-1:0] pending_lo;
    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;
    logic             div_by_zero;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op          (mdu_op),
        .a           (src_a),
        .b           (src_b),
        .hi_next     (arith_hi),
        .lo_next     (arith_lo),
        .div_by_zero (div_by_zero)
    );

    assign busy = (count != '0);

    // Busy window length depends only on whether the issuing op multiplies or divides.
    always_comb begin
        issue_lat = CNT_W'(DIV_LAT);
        if ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU))
            issue_lat = CNT_W'(MULT_LAT);
    end

    // Issue, countdown and commit; a divide by zero latches the current hi/lo so commit is a no-op.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
        end else if (busy) begin
            if (count == CNT_W'(1)) begin
                hi <= pending_hi;
                lo <= pending_lo;
            end
            count <= count - CNT_W'(1);
        end else if (start) begin
            if (is_md_op(mdu_op)) begin
                pending_hi <= div_by_zero ? hi : arith_hi;
                pending_lo <= div_by_zero ? lo : arith_lo;
                count      <= issue_lat;
            end else if (mdu_op == MDU_MTHI) begin
                hi <= src_a;
            end else if (mdu_op == MDU_MTLO) begin
                lo <= src_a;
            end
        end
    end

    // MFHI/MFLO read the architectural registers directly; everything else reads zero.
    always_comb begin
        result = '0;
        case (mdu_op)
            MDU_MFHI: result = hi;
            MDU_MFLO: result = lo;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_e_mul_div_unit.sv
// Scoreboard testbench for e_mul_div_unit with a plain-arithmetic reference model.
module tb_e_mul_div_unit;
    import mdu_pkg::*;

    localparam int W   = 32;
    localparam int ML  = 5;
    localparam int DL  = 10;
    localparam int W8  = 8;
    localparam int ML8 = 1;
    localparam int DL8 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mdu_op = MDU_NONE;
    logic        start = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [3:0]  op8 = MDU_NONE;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic [7:0]  result8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    e_mul_div_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .mdu_op(mdu_op), .start(start),
        .src_a(src_a), .src_b(src_b), .busy(busy), .result(result),
        .hi(hi), .lo(lo)
    );

    e_mul_div_unit #(.WIDTH(W8), .MULT_LAT(ML8), .DIV_LAT(DL8)) dut8 (
        .clk(clk), .reset(reset), .mdu_op(op8), .start(start8),
        .src_a(a8), .src_b(b8), .busy(busy8), .result(result8),
        .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          assert_count = 0;
    int          fail_count = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    bit          p_valid = 1'b0;
    int          p_edge = 0;
    int          p_lat = 0;
    logic [7:0]  m8_hi = '0;
    logic [7:0]  m8_lo = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void ref_calc(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] cur_hi, input logic [63:0] cur_lo, input int w,
                                     output logic [63:0] h, output logic [63:0] l);
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb_v, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb_v = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        h = cur_hi;
        l = cur_lo;
        if (op == 4'd1) begin
            q = sa * sb_v;
            h = (q >>> w) & mask;
            l = q & mask;
        end else if (op == 4'd2) begin
            p = ua * ub;
            h = (p >> w) & mask;
            l = p & mask;
        end else if (op == 4'd3 && ub != 0) begin
            if (sa == -(longint'(1) << (w - 1)) && sb_v == -1) begin
                l = 64'd1 << (w - 1);
                h = 0;
            end else begin
                q = sa / sb_v;
                r = sa % sb_v;
                l = q & mask;
                h = r & mask;
            end
        end else if (op == 4'd4 && ub != 0) begin
            l = ua / ub;
            h = ua % ub;
        end
    endfunction

    task automatic sync_model(input int n);
        if (p_valid && n >= p_edge + p_lat) begin
            m_hi    = p_hi;
            m_lo    = p_lo;
            p_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] h, l;
        sync_model(cyc);
        if (!p_valid) begin
            if (op >= 4'd1 && op <= 4'd4) begin
                ref_calc(op, {32'd0, a}, {32'd0, b}, {32'd0, m_hi}, {32'd0, m_lo}, W, h, l);
                p_hi    = h[31:0];
                p_lo    = l[31:0];
                p_valid = 1'b1;
                p_edge  = cyc + 1;
                p_lat   = (op <= 4'd2) ? ML : DL;
                sb.push_back('{p_hi, p_lo, p_lat});
            end else if (op == 4'd7) begin
                m_hi = a;
            end else if (op == 4'd8) begin
                m_lo = a;
            end
        end
        mdu_op = op;
        src_a  = a;
        src_b  = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = MDU_NONE;
    endtask

    task automatic checkRead(input logic [3:0] op);
        logic [31:0] expv;
        sync_model(cyc);
        expv   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        mdu_op = op;
        start  = 1'b1;
        #1;
        checkOutput($sformatf("read_op%0d", op), result, expv);
        start  = 1'b0;
        mdu_op = MDU_NONE;
    endtask

    task automatic doReset(input int cycles);
        sync_model(cyc);
        if (p_valid) begin
            void'(sb.pop_back());
            sb.push_back('{32'd0, 32'd0, (cyc + 1) - p_edge});
            p_valid = 1'b0;
        end
        m_hi  = '0;
        m_lo  = '0;
        m8_hi = '0;
        m8_lo = '0;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitIdle();
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL wait_idle: busy still 0x%0h after 40 cycles, expected 0x0", busy);
        end
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [63:0] h, l;
        int          n;
        int          lat;
        ref_calc(op, {56'd0, a}, {56'd0, b}, {56'd0, m8_hi}, {56'd0, m8_lo}, W8, h, l);
        lat    = (op <= 4'd2) ? ML8 : DL8;
        op8    = op;
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        op8    = MDU_NONE;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy8 === 1'b1) n++;
            else break;
        end
        checkOutput($sformatf("w8_busy_op%0d", op), n, lat);
        checkOutput($sformatf("w8_hi_op%0d", op), hi8, h[7:0]);
        checkOutput($sformatf("w8_lo_op%0d", op), lo8, l[7:0]);
        m8_hi = h[7:0];
        m8_lo = l[7:0];
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: on every busy fall, pop the oldest expectation and compare hi/lo and window length.
    bit prev_busy = 1'b0;
    int busy_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            busy_run++;
        end else if (prev_busy) begin
            if (sb.size() == 0) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL sb_unexpected: busy fell with got 0 expectations queued, expected 1");
            end else begin
                e = sb.pop_front();
                checkOutput("done_hi", hi, e.hi);
                checkOutput("done_lo", lo, e.lo);
                checkOutput("busy_cycles", busy_run, e.lat);
            end
            busy_run = 0;
        end
        prev_busy = (busy === 1'b1);
    end

    initial begin
        logic [3:0] rop;
        doReset(2);
        @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_busy8", busy8, 1'b0);
        checkRead(MDU_MFHI);

        applyStimulus(MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        checkOutput("busy_after_issue", busy, 1'b1);
        waitIdle();
        checkOutput("mult_hi_const", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo_const", lo, 32'hFFFF_FFFE);
        applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        waitIdle();
        checkOutput("multu_hi_const", hi, 32'h0000_0001);
        applyStimulus(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        waitIdle();
        checkOutput("div_lo_const", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi_const", hi, 32'hFFFF_FFFF);
        applyStimulus(MDU_DIVU, 32'd7, 32'd2);
        waitIdle();
        applyStimulus(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle();
        checkOutput("div_ovf_lo_const", lo, 32'h8000_0000);

        applyStimulus(MDU_MTHI, 32'h1234, 32'd0);
        checkRead(MDU_MFHI);
        applyStimulus(MDU_MTLO, 32'h5678, 32'd0);
        checkRead(MDU_MFLO);
        applyStimulus(MDU_DIV, 32'hDEAD_BEEF, 32'd0);
        waitIdle();
        checkRead(MDU_MFHI);
        checkOutput("dbz_lo_const", lo, 32'h5678);

        applyStimulus(MDU_DIVU, 32'd1000, 32'd7);
        @(posedge clk);
        #1;
        applyStimulus(MDU_MTLO, 32'hAAAA, 32'd0);
        applyStimulus(MDU_MULT, 32'd9, 32'd9);
        checkRead(MDU_MFLO);
        checkRead(MDU_MFHI);
        waitIdle();
        checkRead(MDU_MFLO);

        applyStimulus(MDU_MULT, 32'd123, 32'd456);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        doReset(1);
        checkOutput("rst_mid_busy", busy, 1'b0);
        checkOutput("rst_mid_hi", hi, 32'd0);
        checkOutput("rst_mid_lo", lo, 32'd0);
        applyStimulus(MDU_MULTU, 32'd3, 32'd4);
        waitIdle();
        checkOutput("post_rst_lo_const", lo, 32'd12);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) waitIdle();
            applyStimulus(rop, pick(), pick());
            if ($urandom_range(0, 2) == 0) checkRead(($urandom_range(0, 1) == 0) ? MDU_MFHI : MDU_MFLO);
        end
        waitIdle();
        checkRead(MDU_MFHI);
        checkRead(MDU_MFLO);
        checkRead(MDU_MTHI);

        run8(MDU_MULT, 8'h80, 8'h80);
        checkOutput("w8_mult_hi_const", hi8, 8'h40);
        run8(MDU_DIV, 8'h80, 8'hFF);
        run8(MDU_DIV, 8'hF9, 8'h02);
        run8(MDU_DIVU, 8'h33, 8'h00);
        for (int i = 0; i < 8; i++)
            run8(4'($urandom_range(1, 4)), 8'($urandom), 8'($urandom));

        @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
